// File: rtl/out_channel_checker.sv
// Streaming in-order checker for the core's output channel.
// Buffers words in a small FIFO and compares them against a preloaded table.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 12,
  parameter int AddrWidth = 4,
  parameter int FifoDepth = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          exp_we,
  input  logic [AddrWidth-1:0]          exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          start,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          halt,
  output logic                          finished,
  output logic                          success,
  output logic [AddrWidth:0]            received,
  output logic [AddrWidth-1:0]          mismatch_index
);

  localparam int PW = $clog2(FifoDepth);
  localparam logic [AddrWidth:0] NOUT = (AddrWidth+1)'(NOut);
  localparam logic [AddrWidth:0] NOUT1 = (AddrWidth+1)'(NOut + 1);
  localparam logic [PW:0] FULL = (PW+1)'(FifoDepth);

  typedef enum logic [1:0] {LOAD, CHECK, DONE} state_t;

  state_t state, state_next;

  logic [MemoryElementWidth-1:0] expected [2**AddrWidth];
  logic [MemoryElementWidth-1:0] fifo [FifoDepth];

  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic [AddrWidth:0]   pushed, received_q;
  logic [AddrWidth-1:0] mismatch_idx_q;
  logic                 halt_seen, mismatch, overflow, success_q;

  logic full, empty, transfer, pop, enter_check;
  logic [MemoryElementWidth-1:0] head, ref_word;

  assign full = (count == FULL);
  assign empty = (count == '0);
  assign out_ready = (state == CHECK) && !full;
  assign transfer = out_valid && out_ready;
  assign pop = (state == CHECK) && !empty;
  assign enter_check = (state != CHECK) && start;
  assign head = fifo[rd_ptr];
  assign ref_word = expected[received_q[AddrWidth-1:0]];

  assign finished = (state == DONE);
  assign success = success_q;
  assign received = received_q;
  assign mismatch_index = mismatch_idx_q;

  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:  if (start) state_next = CHECK;
      CHECK: if ((halt || halt_seen) && empty && !transfer)
               state_next = DONE;
      DONE:  if (start) state_next = CHECK;
      default: state_next = LOAD;
    endcase
  end

  // Table survives reset so a rerun needs no reload.
  always_ff @(posedge clock) begin
    if (exp_we && state != CHECK && {1'b0, exp_addr} < NOUT)
      expected[exp_addr] <= exp_data;
  end

  always_ff @(posedge clock) begin
    if (transfer) fifo[wr_ptr] <= out_data;
  end

  always_ff @(posedge clock) begin
    if (reset || enter_check) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pushed         <= '0;
      received_q     <= '0;
      mismatch_idx_q <= '0;
      halt_seen      <= 1'b0;
      mismatch       <= 1'b0;
      overflow       <= 1'b0;
      success_q      <= 1'b0;
    end else if (state == CHECK) begin
      if (transfer) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (pushed == NOUT) overflow <= 1'b1;
        if (pushed != NOUT1) pushed <= pushed + (AddrWidth+1)'(1);
      end
      // Words beyond NOut are drained without comparison.
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (received_q < NOUT) begin
          received_q <= received_q + (AddrWidth+1)'(1);
          if (head != ref_word && !mismatch) begin
            mismatch       <= 1'b1;
            mismatch_idx_q <= received_q[AddrWidth-1:0];
          end
        end
      end
      unique case ({transfer, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (halt) halt_seen <= 1'b1;
      if (state_next == DONE)
        success_q <= !mismatch && !overflow && received_q == NOUT;
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed self-checking bench for out_channel_checker.
// Runs pass, mismatch, short, overflow, reset and rerun scenarios.
module tb_out_channel_checker;

  localparam int W = 12;
  localparam int N = 12;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic          start;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          halt;
  logic          finished;
  logic          success;
  logic [AW:0]   received;
  logic [AW-1:0] mismatch_index;

  int checks = 0;
  int errors = 0;
  int ready_drops = 0;
  int lat;

  logic [W-1:0] table_v [N] = '{3, 2, 1, 0, 3, 2, 1, 0, 0, 1, 2, 3};
  logic [W-1:0] words [16];

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NOut(N),
    .AddrWidth(AW),
    .FifoDepth(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .exp_we(exp_we),
    .exp_addr(exp_addr),
    .exp_data(exp_data),
    .start(start),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .halt(halt),
    .finished(finished),
    .success(success),
    .received(received),
    .mismatch_index(mismatch_index)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_words;
    for (int i = 0; i < 16; i++) words[i] = (i < N) ? table_v[i] : '0;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    out_valid = 1'b1;
    out_data = w;
    n = 0;
    while (!out_ready && n < 20) begin
      ready_drops++;
      tick();
      n++;
    end
    if (!out_ready) chk("ready_timeout", {31'd0, out_ready}, 1);
    tick();
  endtask

  task automatic run(input int n, input bit do_start, output int cyc);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) send(words[i]);
    out_valid = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    cyc = 1;
    while (!finished && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("finished", {31'd0, finished}, 1);
  endtask

  initial begin
    reset = 1'b1;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    start = 1'b0;
    out_valid = 1'b0;
    out_data = '0;
    halt = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, out_ready}, 0);
    chk("rst_finished", {31'd0, finished}, 0);
    chk("rst_success", {31'd0, success}, 0);
    chk("rst_received", {27'd0, received}, 0);
    chk("rst_mm_index", {28'd0, mismatch_index}, 0);

    for (int i = 0; i < N; i++) begin
      exp_we = 1'b1;
      exp_addr = AW'(i);
      exp_data = table_v[i];
      tick();
    end
    exp_we = 1'b0;

    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    chk("load_halt_ignored", {31'd0, finished}, 0);
    chk("load_ready", {31'd0, out_ready}, 0);

    // Pass run; a table write attempted in CHECK must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("check_ready", {31'd0, out_ready}, 1);
    exp_we = 1'b1;
    exp_addr = 4'd1;
    exp_data = 12'd9;
    tick();
    exp_we = 1'b0;
    load_words();
    ready_drops = 0;
    run(N, 1'b0, lat);
    chk("pass_latency", lat, 2);
    chk("pass_success", {31'd0, success}, 1);
    chk("pass_received", {27'd0, received}, 12);
    chk("pass_mm_index", {28'd0, mismatch_index}, 0);
    chk("pass_ready_drops", ready_drops, 0);

    load_words();
    words[9] = 12'd5;
    words[10] = 12'd0;
    run(N, 1'b1, lat);
    chk("mm_success", {31'd0, success}, 0);
    chk("mm_index", {28'd0, mismatch_index}, 9);
    chk("mm_received", {27'd0, received}, 12);

    load_words();
    run(11, 1'b1, lat);
    chk("short_success", {31'd0, success}, 0);
    chk("short_received", {27'd0, received}, 11);
    chk("short_mm_index", {28'd0, mismatch_index}, 0);

    load_words();
    words[12] = 12'd3;
    run(13, 1'b1, lat);
    chk("ovf_success", {31'd0, success}, 0);
    chk("ovf_received", {27'd0, received}, 12);
    chk("ovf_mm_index", {28'd0, mismatch_index}, 0);

    load_words();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send(words[i]);
    out_valid = 1'b0;
    chk("mid_received", {27'd0, received}, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, out_ready}, 0);
    chk("mid_rst_finished", {31'd0, finished}, 0);
    chk("mid_rst_success", {31'd0, success}, 0);
    chk("mid_rst_received", {27'd0, received}, 0);
    chk("mid_rst_mm_index", {28'd0, mismatch_index}, 0);
    run(N, 1'b1, lat);
    chk("retain_success", {31'd0, success}, 1);
    chk("retain_received", {27'd0, received}, 12);

    exp_we = 1'b1;
    exp_addr = 4'd0;
    exp_data = 12'd7;
    tick();
    exp_we = 1'b0;
    chk("done_still_finished", {31'd0, finished}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_finished_drop", {31'd0, finished}, 0);
    chk("rerun_success_drop", {31'd0, success}, 0);
    load_words();
    words[0] = 12'd7;
    run(N, 1'b0, lat);
    chk("rerun_success", {31'd0, success}, 1);
    chk("rerun_received", {27'd0, received}, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
